// File: rtl/ford_lamp_pkg.sv
// Shared state encoding and lamp step patterns for the tail-lamp sequencer.
package ford_lamp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERR   = 3'd1,
    ST_SEQ_L = 3'd2,
    ST_SEQ_R = 3'd3,
    ST_HAZ   = 3'd4
  } state_t;

  localparam logic [2:0] LAMPS_ON  = 3'b111;
  localparam logic [2:0] LAMPS_OFF = 3'b000;

  // Element n is the pattern for step n; the sweep grows outward from the inner lamp.
  localparam logic [3:0][2:0] L_PAT = {3'b111, 3'b011, 3'b001, 3'b000};
  localparam logic [3:0][2:0] R_PAT = {3'b111, 3'b110, 3'b100, 3'b000};

endpackage

// File: rtl/lamp_tick_gen.sv
// Step prescaler: emits a one-cycle tick every TICK_DIV cycles, restartable via clr.
module lamp_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clka,
  input  logic RESTART_N,
  input  logic clr,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(TICK_DIV - 1));

  always_ff @(posedge clka or negedge RESTART_N) begin
    if (!RESTART_N) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ford_lamp_sequencer.sv
// Tail-lamp sequencer: brake, left/right sweep, hazard flash and conflicting-request error.
module ford_lamp_sequencer
  import ford_lamp_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clka,
  input  logic       RESTART_N,
  input  logic       BRAKE,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       HAZARD,
  output logic [2:0] L,
  output logic [2:0] R,
  output logic       ERROR,
  output logic       BUSY,
  output logic [2:0] p_state
);

  state_t     state, state_n;
  logic [1:0] step, step_n;
  logic       tick, clr;
  logic [2:0] l_n, r_n;
  logic       err_n, busy_n;
  logic [2:0] brake_lamps;

  lamp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clka      (clka),
    .RESTART_N (RESTART_N),
    .clr       (clr),
    .tick      (tick)
  );

  assign brake_lamps = BRAKE ? LAMPS_ON : LAMPS_OFF;
  assign p_state     = state;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (HAZARD)              state_n = ST_HAZ;
        else if (LEFT && RIGHT)  state_n = ST_ERR;
        else if (LEFT)           state_n = ST_SEQ_L;
        else if (RIGHT)          state_n = ST_SEQ_R;
      end
      ST_ERR:   state_n = (LEFT && RIGHT) ? ST_ERR : ST_IDLE;
      ST_SEQ_L, ST_SEQ_R: begin
        if (HAZARD)                    state_n = ST_HAZ;
        else if (tick && step == 2'd3) state_n = ST_IDLE;
      end
      ST_HAZ:   if (!HAZARD) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Any state change restarts both the prescaler and the step count.
  assign clr = (state_n != state);

  always_comb begin
    step_n = step;
    if (clr)       step_n = 2'd0;
    else if (tick) step_n = step + 2'd1;
  end

  // Outputs are decoded from the upcoming state so they change on the same edge.
  always_comb begin
    l_n    = LAMPS_OFF;
    r_n    = LAMPS_OFF;
    err_n  = 1'b0;
    busy_n = 1'b0;
    case (state_n)
      ST_IDLE: begin
        l_n = brake_lamps;
        r_n = brake_lamps;
      end
      ST_ERR:   err_n = 1'b1;
      ST_SEQ_L: begin
        l_n    = L_PAT[step_n];
        r_n    = brake_lamps;
        busy_n = 1'b1;
      end
      ST_SEQ_R: begin
        l_n    = brake_lamps;
        r_n    = R_PAT[step_n];
        busy_n = 1'b1;
      end
      ST_HAZ: begin
        l_n    = step_n[0] ? LAMPS_OFF : LAMPS_ON;
        r_n    = step_n[0] ? LAMPS_OFF : LAMPS_ON;
        busy_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clka or negedge RESTART_N) begin
    if (!RESTART_N) begin
      state <= ST_IDLE;
      step  <= 2'd0;
      L     <= LAMPS_OFF;
      R     <= LAMPS_OFF;
      ERROR <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      L     <= l_n;
      R     <= r_n;
      ERROR <= err_n;
      BUSY  <= busy_n;
    end
  end

endmodule

// File: tb/tb_ford_lamp_sequencer.sv
// Bench for ford_lamp_sequencer: directed scenarios plus randomized traffic against a timing model.
module tb_ford_lamp_sequencer;

  localparam int TD = 4;

  logic       clka = 1'b0;
  logic       rst_n = 1'b0;
  logic       brake = 1'b0, left = 1'b0, right = 1'b0, hazard = 1'b0;
  logic [2:0] dut_l, dut_r, dut_p_state;
  logic       dut_err, dut_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  // Model: mode uses the documented state numbers, m_t counts cycles spent in that mode.
  int         m_state = 0;
  int         m_t     = 0;
  logic [2:0] m_l = 3'd0, m_r = 3'd0;
  logic       m_err = 1'b0, m_busy = 1'b0;

  ford_lamp_sequencer #(.TICK_DIV(TD)) dut (
    .clka      (clka),
    .RESTART_N (rst_n),
    .BRAKE     (brake),
    .LEFT      (left),
    .RIGHT     (right),
    .HAZARD    (hazard),
    .L         (dut_l),
    .R         (dut_r),
    .ERROR     (dut_err),
    .BUSY      (dut_busy),
    .p_state   (dut_p_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clka = ~clka;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int nxt, nstep, lp, rp;
    logic [2:0] bl;
    if (!rst_n) begin
      m_state = 0; m_t = 0;
      m_l = 3'd0; m_r = 3'd0; m_err = 1'b0; m_busy = 1'b0;
      return;
    end
    case (m_state)
      0: begin
        if (hazard)              nxt = 4;
        else if (left && right)  nxt = 1;
        else if (left)           nxt = 2;
        else if (right)          nxt = 3;
        else                     nxt = 0;
      end
      1: nxt = (left && right) ? 1 : 0;
      2, 3: begin
        if (hazard)                nxt = 4;
        else if (m_t == 4*TD - 1)  nxt = 0;
        else                       nxt = m_state;
      end
      4: nxt = hazard ? 4 : 0;
      default: nxt = 0;
    endcase
    if (nxt != m_state) m_t = 0;
    else m_t = m_t + 1;
    m_state = nxt;
    nstep = (m_t / TD) % 4;
    lp = (1 << nstep) - 1;
    rp = 7 & ~((1 << (3 - nstep)) - 1);
    bl = brake ? 3'b111 : 3'b000;
    m_err  = (m_state == 1);
    m_busy = (m_state >= 2);
    case (m_state)
      0: begin m_l = bl; m_r = bl; end
      2: begin m_l = 3'(lp); m_r = bl; end
      3: begin m_l = bl; m_r = 3'(rp); end
      4: begin m_l = (nstep % 2 == 0) ? 3'b111 : 3'b000; m_r = m_l; end
      default: begin m_l = 3'b000; m_r = 3'b000; end
    endcase
  endtask

  initial forever begin
    @(posedge clka or negedge rst_n);
    model_step();
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clka) begin
    if (chk_en) begin
      chk("cyc_L",     8'(dut_l),       8'(m_l));
      chk("cyc_R",     8'(dut_r),       8'(m_r));
      chk("cyc_ERROR", 8'(dut_err),     8'(m_err));
      chk("cyc_BUSY",  8'(dut_busy),    8'(m_busy));
      chk("cyc_state", 8'(dut_p_state), 8'(m_state));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clka);
    #2;
  endtask

  task automatic chk_lamps(input string name, input logic [2:0] l, input logic [2:0] r,
                           input logic [2:0] st);
    chk({name, "_L"}, 8'(dut_l), 8'(l));
    chk({name, "_R"}, 8'(dut_r), 8'(r));
    chk({name, "_state"}, 8'(dut_p_state), 8'(st));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hz_cnt;
    hz_cnt = 0;
    edges(3);
    chk_lamps("reset", 3'b000, 3'b000, 3'd0);
    chk("reset_ERROR", 8'(dut_err), 8'd0);
    chk("reset_BUSY", 8'(dut_busy), 8'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    edges(2);

    // Left sweep from a one-cycle request
    left = 1'b1;
    edges(1);
    left = 1'b0;
    chk_lamps("left_s0", 3'b000, 3'b000, 3'd2);
    chk("left_busy", 8'(dut_busy), 8'd1);
    edges(4); chk_lamps("left_s1", 3'b001, 3'b000, 3'd2);
    edges(4); chk_lamps("left_s2", 3'b011, 3'b000, 3'd2);
    edges(4); chk_lamps("left_s3", 3'b111, 3'b000, 3'd2);
    chk("left_busy_end", 8'(dut_busy), 8'd1);
    edges(4); chk_lamps("left_done", 3'b000, 3'b000, 3'd0);
    chk("left_idle_busy", 8'(dut_busy), 8'd0);
    edges(2);

    // Right sweep with brake held
    brake = 1'b1; right = 1'b1;
    edges(1);
    right = 1'b0;
    chk_lamps("right_s0", 3'b111, 3'b000, 3'd3);
    edges(4); chk_lamps("right_s1", 3'b111, 3'b100, 3'd3);
    edges(4); chk_lamps("right_s2", 3'b111, 3'b110, 3'd3);
    edges(4); chk_lamps("right_s3", 3'b111, 3'b111, 3'd3);
    edges(4); chk_lamps("right_done", 3'b111, 3'b111, 3'd0);
    brake = 1'b0;
    edges(1); chk_lamps("brake_rel", 3'b000, 3'b000, 3'd0);

    // Conflict error, then recovery into a left sweep
    left = 1'b1; right = 1'b1; brake = 1'b1;
    edges(1);
    chk_lamps("err", 3'b000, 3'b000, 3'd1);
    chk("err_flag", 8'(dut_err), 8'd1);
    right = 1'b0; brake = 1'b0;
    edges(1); chk_lamps("err_exit", 3'b000, 3'b000, 3'd0);
    edges(1); chk_lamps("err_to_left", 3'b000, 3'b000, 3'd2);
    left = 1'b0;
    edges(18);

    // Hazard pre-empting a right sweep at step 2
    right = 1'b1;
    edges(1);
    right = 1'b0;
    edges(8);
    chk_lamps("pre_haz", 3'b000, 3'b110, 3'd3);
    hazard = 1'b1;
    edges(1); chk_lamps("haz_on", 3'b111, 3'b111, 3'd4);
    brake = 1'b1;
    edges(4); chk_lamps("haz_off", 3'b000, 3'b000, 3'd4);
    brake = 1'b0;
    edges(4); chk_lamps("haz_on2", 3'b111, 3'b111, 3'd4);
    hazard = 1'b0;
    edges(1); chk_lamps("haz_exit", 3'b000, 3'b000, 3'd0);

    // Asynchronous reset in the middle of a left sweep
    left = 1'b1;
    edges(1);
    left = 1'b0;
    edges(8);
    chk_lamps("pre_rst", 3'b011, 3'b000, 3'd2);
    rst_n = 1'b0;
    #1;
    chk_lamps("async_rst", 3'b000, 3'b000, 3'd0);
    chk("async_rst_busy", 8'(dut_busy), 8'd0);
    edges(2);
    rst_n = 1'b1;

    // Brake alone in idle
    brake = 1'b1;
    edges(1); chk_lamps("brake_on", 3'b111, 3'b111, 3'd0);
    brake = 1'b0;
    edges(1); chk_lamps("brake_off", 3'b000, 3'b000, 3'd0);

    // Randomized traffic with occasional hazard bursts and mid-cycle resets
    for (int i = 0; i < 4000; i++) begin
      edges(1);
      if (hz_cnt > 0) begin
        hazard = 1'b1;
        hz_cnt--;
      end else begin
        hazard = 1'b0;
        if ($urandom_range(0, 39) == 0) hz_cnt = $urandom_range(1, 20);
      end
      left  = ($urandom_range(0, 5) == 0);
      right = ($urandom_range(0, 5) == 0);
      brake = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
      end
    end

    edges(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
